mux_arb_reg: RTL and testbench

- Parametrised N-channel, W-bit registered selector; successor to the fixed 16:1 2-bit combinational mux.
- Adds per-channel valid/ready handshakes, a registered output stage with backpressure, and two selection modes: fixed (index-driven) and round-robin arbitration.
- Used wherever the core funnels several producers (forwarding sources, request queues) into one consumer.

---
 rtl/mux_arb_reg_if.sv | 28 ++
 rtl/mux_arb_reg.sv | 114 +++++++++++
 tb/tb_mux_arb_reg.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_reg_if.sv
// Channel-side and consumer-side signals of the registered N:1 selector.
// Direction names are from the point of view of the selector (slave).
interface mux_arb_reg_if #(
    parameter int WIDTH = 2,
    parameter int NCH   = 16
);
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      select;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_chan;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, mode, select, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, select, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_arb_reg.sv
// N-channel registered selector with valid/ready on every channel, a single
// output register with backpressure, and fixed or round-robin channel choice.
module mux_arb_reg #(
    parameter int WIDTH = 2,
    parameter int NCH   = 16
) (
    input  logic          clk,
    input  logic          rst,
    mux_arb_reg_if.slave  bus
);
    localparam int              SELW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [WIDTH-1:0] ch_data [NCH];
    logic [NCH-1:0]   in_ready_vec;

    logic [SELW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [SELW-1:0]  out_chan_reg, out_chan_next;
    logic             out_valid_reg, out_valid_next;

    logic             load_en;
    logic             sel_ok;
    logic             rr_found;
    logic [SELW-1:0]  rr_chan;
    logic [SELW:0]    scan_sum;
    logic [SELW-1:0]  scan_idx;
    logic             grant;
    logic [SELW-1:0]  grant_chan;
    logic             xfer;

    assign load_en = !out_valid_reg || bus.out_ready;
    assign xfer    = load_en && grant;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_data[gi]      = bus.in_data[gi*WIDTH +: WIDTH];
            assign in_ready_vec[gi] = xfer && (grant_chan == SELW'(gi));
        end
    endgenerate

    assign bus.in_ready = in_ready_vec;

    // Scan starts one past the last round-robin winner, so the previous winner
    // is only re-granted once every other channel has been passed over.
    always_comb begin
        rr_found = 1'b0;
        rr_chan  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 1; k <= NCH; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (SELW+1)'(k);
            if (scan_sum >= NCH_W) begin
                scan_sum = scan_sum - NCH_W;
            end
            scan_idx = scan_sum[SELW-1:0];
            if (!rr_found && bus.in_valid[scan_idx]) begin
                rr_found = 1'b1;
                rr_chan  = scan_idx;
            end
        end
    end

    assign sel_ok = ({1'b0, bus.select} < NCH_W);

    always_comb begin
        grant      = 1'b0;
        grant_chan = '0;
        if (bus.mode) begin
            grant      = rr_found;
            grant_chan = rr_chan;
        end else if (sel_ok) begin
            grant      = bus.in_valid[bus.select];
            grant_chan = bus.select;
        end
    end

    always_comb begin
        rr_ptr_next    = rr_ptr_reg;
        out_data_next  = out_data_reg;
        out_chan_next  = out_chan_reg;
        out_valid_next = out_valid_reg;
        if (xfer) begin
            out_data_next  = ch_data[grant_chan];
            out_chan_next  = grant_chan;
            out_valid_next = 1'b1;
            if (bus.mode) begin
                rr_ptr_next = grant_chan;
            end
        end else if (bus.out_ready) begin
            // Drained with nothing to replace it: data/chan keep the last word.
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= LAST_CH;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            out_data_reg  <= out_data_next;
            out_chan_reg  <= out_chan_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_chan  = out_chan_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed bench for mux_arb_reg: a 16-channel instance checked every cycle
// against a distance-based arbitration model, plus a 12-channel instance.
module tb_mux_arb_reg;
    localparam int WIDTH = 2;
    localparam int NCH   = 16;
    localparam int SELW  = 4;
    localparam int NCH2  = 12;
    localparam int SELW2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_arb_reg_if #(.WIDTH(WIDTH), .NCH(NCH))  bus ();
    mux_arb_reg_if #(.WIDTH(WIDTH), .NCH(NCH2)) bus12 ();

    mux_arb_reg #(.WIDTH(WIDTH), .NCH(NCH))  dut   (.clk(clk), .rst(rst), .bus(bus));
    mux_arb_reg #(.WIDTH(WIDTH), .NCH(NCH2)) dut12 (.clk(clk), .rst(rst), .bus(bus12));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the 16-channel instance ----------
    bit               armed = 1'b0;
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    logic [SELW-1:0]  m_chan;
    int               m_ptr;

    // Round robin: among valid channels, pick the one fewest steps after m_ptr.
    function automatic int exp_grant();
        int best;
        int bestd;
        best  = -1;
        bestd = NCH;
        if (bus.mode == 1'b0) begin
            if (int'(bus.select) < NCH && bus.in_valid[bus.select]) return int'(bus.select);
            return -1;
        end
        for (int c = 0; c < NCH; c++) begin
            if (bus.in_valid[c]) begin
                int d;
                d = (c - m_ptr - 1 + 2*NCH) % NCH;
                if (d < bestd) begin
                    bestd = d;
                    best  = c;
                end
            end
        end
        return best;
    endfunction

    always @(negedge clk) begin
        int             g;
        bit             ld;
        logic [NCH-1:0] er;
        g  = exp_grant();
        ld = !m_valid || bus.out_ready;
        er = (ld && g >= 0) ? (NCH'(1) << g) : '0;
        if (armed) begin
            chk("model_out_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("model_out_data",  64'(bus.out_data),  64'(m_data));
            chk("model_out_chan",  64'(bus.out_chan),  64'(m_chan));
            chk("model_in_ready",  64'(bus.in_ready),  64'(er));
            if (bus.out_valid && bus.out_ready)
                $display("xfer out chan=%0d data=%0d t=%0t", bus.out_chan, bus.out_data, $time);
        end
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = '0;
            m_ptr   = NCH - 1;
            armed   = 1'b1;
        end else if (armed) begin
            if (ld && g >= 0) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[g*WIDTH +: WIDTH];
                m_chan  = SELW'(g);
                if (bus.mode) m_ptr = g;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NCH-1:0] v, input logic m, input logic [SELW-1:0] s, input logic r);
        bus.in_valid  = v;
        bus.mode      = m;
        bus.select    = s;
        bus.out_ready = r;
    endtask

    task automatic drive12(input logic [NCH2-1:0] v, input logic m, input logic [SELW2-1:0] s, input logic r);
        bus12.in_valid  = v;
        bus12.mode      = m;
        bus12.select    = s;
        bus12.out_ready = r;
    endtask

    logic [NCH-1:0] seq_ready [4];
    int             seq_chan  [4];

    initial begin
        // Channel i carries (i+2) mod 4: ch5=3, ch7=1, ch9=3, ch11=1.
        for (int i = 0; i < NCH; i++)  bus.in_data[i*WIDTH +: WIDTH]   = WIDTH'(i + 2);
        for (int i = 0; i < NCH2; i++) bus12.in_data[i*WIDTH +: WIDTH] = WIDTH'(i + 2);
        drive(16'h0000, 1'b0, 4'd0, 1'b0);
        drive12(12'h000, 1'b0, 4'd0, 1'b0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset / idle
        at_neg();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data",  64'(bus.out_data),  64'd0);
        chk("rst_out_chan",  64'(bus.out_chan),  64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst12_out_valid", 64'(bus12.out_valid), 64'd0);
        cyc();

        // Fixed mode, channel 5
        drive(16'h0020, 1'b0, 4'd5, 1'b1);
        at_neg();
        chk("fix_in_ready", 64'(bus.in_ready), 64'h0020);
        cyc();
        drive(16'h0000, 1'b0, 4'd5, 1'b1);
        at_neg();
        chk("fix_out_valid", 64'(bus.out_valid), 64'd1);
        chk("fix_out_data",  64'(bus.out_data),  64'd3);
        chk("fix_out_chan",  64'(bus.out_chan),  64'd5);
        cyc();

        // Round-robin skip and wrap; pointer still at 15 from reset
        seq_ready[0] = 16'h0004; seq_ready[1] = 16'h8000;
        seq_ready[2] = 16'h0004; seq_ready[3] = 16'h8000;
        seq_chan[0] = 2; seq_chan[1] = 15; seq_chan[2] = 2; seq_chan[3] = 15;
        drive(16'h8004, 1'b1, 4'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("rr_skip_in_ready", 64'(bus.in_ready), 64'(seq_ready[k]));
            if (k > 0) chk("rr_skip_out_chan", 64'(bus.out_chan), 64'(seq_chan[k-1]));
            cyc();
        end

        // Round-robin fairness, no bubbles
        drive(16'hFFFF, 1'b1, 4'd0, 1'b1);
        for (int k = 0; k < 17; k++) begin
            at_neg();
            chk("rr_fair_in_ready", 64'(bus.in_ready), 64'(NCH'(1) << (k % 16)));
            if (k > 0) begin
                chk("rr_fair_out_valid", 64'(bus.out_valid), 64'd1);
                chk("rr_fair_out_chan",  64'(bus.out_chan),  64'((k - 1) % 16));
            end
            cyc();
        end
        at_neg();
        chk("rr_fair_last_chan", 64'(bus.out_chan), 64'd0);
        cyc();

        // Only the previous winner valid: re-granted after the full scan
        drive(16'h0008, 1'b1, 4'd0, 1'b1);
        cyc();
        at_neg();
        chk("rr_self_in_ready", 64'(bus.in_ready), 64'h0008);
        cyc();

        // Fixed transfer must not move the pointer (still 3): ch4 beats ch10
        drive(16'h0400, 1'b0, 4'd10, 1'b1);
        cyc();
        drive(16'h0410, 1'b1, 4'd0, 1'b1);
        at_neg();
        chk("rr_after_fix_chan", 64'(bus.out_chan), 64'd10);
        chk("rr_after_fix_in_ready", 64'(bus.in_ready), 64'h0010);
        cyc();

        // Backpressure: hold channel 7 while channel 9 waits
        drive(16'h0080, 1'b0, 4'd7, 1'b1);
        cyc();
        drive(16'h0200, 1'b0, 4'd9, 1'b0);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_out_data",  64'(bus.out_data),  64'd1);
            chk("bp_out_chan",  64'(bus.out_chan),  64'd7);
            cyc();
        end
        drive(16'h0200, 1'b0, 4'd9, 1'b1);
        at_neg();
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'h0200);
        cyc();
        drive(16'h0200, 1'b0, 4'd9, 1'b0);
        at_neg();
        chk("bp_release_out_chan", 64'(bus.out_chan), 64'd9);
        chk("bp_release_out_data", 64'(bus.out_data), 64'd3);
        cyc();

        // Reset while a word is held under backpressure
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(16'h0000, 1'b0, 4'd0, 1'b0);
        at_neg();
        chk("hold_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("hold_rst_out_chan",  64'(bus.out_chan),  64'd0);
        cyc();

        // 12-channel instance: out-of-range select and invalid select
        drive12(12'hFFF, 1'b0, 4'd13, 1'b1);
        at_neg();
        chk("n12_oob_in_ready", 64'(bus12.in_ready), 64'd0);
        cyc();
        at_neg();
        chk("n12_oob_out_valid", 64'(bus12.out_valid), 64'd0);
        cyc();
        drive12(12'hFF7, 1'b0, 4'd3, 1'b1);
        at_neg();
        chk("n12_inv_in_ready", 64'(bus12.in_ready), 64'd0);
        cyc();
        at_neg();
        chk("n12_inv_out_valid", 64'(bus12.out_valid), 64'd0);
        cyc();
        drive12(12'hFFF, 1'b0, 4'd11, 1'b1);
        at_neg();
        chk("n12_top_in_ready", 64'(bus12.in_ready), 64'h800);
        cyc();
        drive12(12'hFFF, 1'b1, 4'd0, 1'b1);
        at_neg();
        chk("n12_top_out_chan", 64'(bus12.out_chan), 64'd11);
        chk("n12_top_out_data", 64'(bus12.out_data), 64'd1);
        chk("n12_rr_wrap_in_ready", 64'(bus12.in_ready), 64'h001);
        cyc();
        drive12(12'h000, 1'b0, 4'd0, 1'b1);
        at_neg();
        chk("n12_rr_wrap_out_chan", 64'(bus12.out_chan), 64'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
